// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types and defaults for the key_event_scan front end.
// Optional feature macro: KEY_REPEAT_EN (long-press auto-repeat).
package key_scan_pkg;

  // Per-key event FSM. HELD is only reachable when auto-repeat is built in.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_fsm_e;

  // Default cycle counts for a 50 MHz clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000; // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;  // 100 ms

  // Larger of two cycle counts, used to size the shared hold counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchroniser, debounce counter,
// press/release FSM and, with KEY_REPEAT_EN defined, the hold counter that
// produces long-press auto-repeat ticks. All event outputs are registered.
module key_debounce_ch
  import key_scan_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_pin,
  output logic     key_state,
  output logic     key_press,
  output logic     key_release,
  output logic     key_repeat,
  output logic     flag_next,
  output key_fsm_e fsm_state
);

  localparam int  DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit  REL_LVL = ACTIVE_LOW;  // pin level of a released key

  logic          sync1_q, sync2_q;
  logic          raw;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          state_q, state_d;
  logic          toggle, rise, fall;
  key_fsm_e      fsm_q, fsm_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
`ifdef KEY_REPEAT_EN
  localparam int HW = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES) + 1);
  logic          repeat_q, repeat_d;
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Two-flop synchroniser, parked at the released level during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_pin;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity so that 1 always means pressed.
  assign raw = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Debounce: count while the synchronised level disagrees, accept it once stable long enough.
  always_comb begin
    db_cnt_d = '0;
    state_d  = state_q;
    toggle   = 1'b0;
    if (raw != state_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        toggle  = 1'b1;
        state_d = ~state_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rise = toggle & ~state_q;
  assign fall = toggle &  state_q;

  // Debounced level and its stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      state_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
    end
  end

  // Event FSM next state; a release always wins over a coincident repeat tick.
  always_comb begin
    fsm_d     = fsm_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d  = 1'b0;
    hold_d    = hold_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (rise) begin
          fsm_d   = PRESSED;
          press_d = 1'b1;
`ifdef KEY_REPEAT_EN
          hold_d  = '0;
`endif
        end
      end
      PRESSED: begin
        if (fall) begin
          fsm_d     = IDLE;
          release_d = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          fsm_d    = HELD;
          repeat_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
`ifdef KEY_REPEAT_EN
      HELD: begin
        if (fall) begin
          fsm_d     = IDLE;
          release_d = 1'b1;
        end else if (hold_q == HW'(REPEAT_CYCLES - 1)) begin
          repeat_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
`endif
      default: fsm_d = IDLE;
    endcase
  end

  // FSM state and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q  <= 1'b0;
      hold_q    <= '0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_REPEAT_EN
      repeat_q  <= repeat_d;
      hold_q    <= hold_d;
`endif
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign fsm_state   = fsm_q;
`ifdef KEY_REPEAT_EN
  assign key_repeat  = repeat_q;
  assign flag_next   = press_d | repeat_d;
`else
  assign key_repeat  = 1'b0;
  assign flag_next   = press_d;
`endif

endmodule

// File: rtl/key_event_scan.sv
// key_event_scan: KEY_WIDTH independent debounced keys with per-key press,
// release and (with KEY_REPEAT_EN defined) long-press repeat pulses.
// key_flag is a registered OR of press|repeat across all keys, aligned with them.
// key_fsm_state exposes each channel's FSM state, 2 bits per key.
module key_event_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned KEY_WIDTH       = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_WIDTH-1:0]   key_data,
  output logic [KEY_WIDTH-1:0]   key_state,
  output logic [KEY_WIDTH-1:0]   key_press,
  output logic [KEY_WIDTH-1:0]   key_release,
  output logic [KEY_WIDTH-1:0]   key_repeat,
  output logic                   key_flag,
  output logic [2*KEY_WIDTH-1:0] key_fsm_state
);

  logic [KEY_WIDTH-1:0] flag_next;
  logic                 key_flag_q, key_flag_d;

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_ch
    key_fsm_e ch_state;

    key_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_pin     (key_data[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i]),
      .flag_next   (flag_next[i]),
      .fsm_state   (ch_state)
    );

    assign key_fsm_state[2*i +: 2] = ch_state;
  end

  // Next value of the combined event flag, taken from the channels' next-cycle pulses.
  always_comb begin
    key_flag_d = |flag_next;
  end

  // Register the flag so it lines up with the registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_flag_q <= 1'b0;
    else        key_flag_q <= key_flag_d;
  end

  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_event_scan.sv
// tb_key_event_scan: directed bench for key_event_scan (KEY_WIDTH=4, active-low,
// DEBOUNCE=16, LONG=64, REPEAT=8). Repeat expectations follow KEY_REPEAT_EN.
module tb_key_event_scan;
  import key_scan_pkg::*;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int LAT = 18;  // posedges from input change to visible event

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_data = 4'b1111;
  logic [3:0] key_state, key_press, key_release, key_repeat;
  logic       key_flag;
  logic [7:0] key_fsm_state;

  always #5 clk = ~clk;

  key_event_scan #(
    .KEY_WIDTH       (4),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (16),
    .LONG_CYCLES     (64),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_data      (key_data),
    .key_state     (key_state),
    .key_press     (key_press),
    .key_release   (key_release),
    .key_repeat    (key_repeat),
    .key_flag      (key_flag),
    .key_fsm_state (key_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] st, input logic [3:0] pr,
                            input logic [3:0] rl, input logic [3:0] rp, input logic fl);
    check({tag, ".state"},   {4'b0, key_state},   {4'b0, st});
    check({tag, ".press"},   {4'b0, key_press},   {4'b0, pr});
    check({tag, ".release"}, {4'b0, key_release}, {4'b0, rl});
    check({tag, ".repeat"},  {4'b0, key_repeat},  {4'b0, rp});
    check({tag, ".flag"},    {7'b0, key_flag},    {7'b0, fl});
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] din;
    int         wait_n;
    logic [3:0] st, pr, rl, rp;
    logic       fl;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_press;
    logic [3:0] e_st, e_pr, e_rl, e_rp;

    // Clean press/release, simultaneous keys and independent keys.
    vecs[0]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1110, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vecs[3]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4]  = '{4'b1111, 17, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{4'b0110, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0110,  1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b1};
    vecs[9]  = '{4'b0110,  1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[10] = '{4'b1111, 18, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b0};
    vecs[11] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{4'b1110, 18, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vecs[13] = '{4'b0110, 18, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 1'b1};
    vecs[14] = '{4'b1111, 18, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b0};
    vecs[15] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    // Reset state, before any clock edge.
    #2;
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("reset.fsm", key_fsm_state, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven vectors.
    for (int v = 0; v < 16; v++) begin
      key_data = vecs[v].din;
      repeat (vecs[v].wait_n) step();
      check_outs($sformatf("vec%0d", v), vecs[v].st, vecs[v].pr, vecs[v].rl, vecs[v].rp, vecs[v].fl);
    end

    // Bounce rejection: 15-cycle low glitches on key 1 never get accepted.
    for (int g = 0; g < 5; g++) begin
      key_data = 4'b1101;
      for (int c = 0; c < 20; c++) begin
        if (c == 15) key_data = 4'b1111;
        step();
        check_outs($sformatf("bounce%0d_%0d", g, c), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
    end
    check("bounce.fsm", key_fsm_state, 8'h00);

    // Long press on key 2, released so the state falls on a repeat-tick cycle.
    for (int k = 0; k < 5; k++) exp_q.push_back(8'(LAT + 64 + 8 * k));
    key_data = 4'b1011;
    for (int t = 1; t <= 130; t++) begin
      step();
      e_st = (t >= LAT && t < LAT + 104) ? 4'b0100 : 4'b0000;
      e_pr = (t == LAT) ? 4'b0100 : 4'b0000;
      e_rl = (t == LAT + 104) ? 4'b0100 : 4'b0000;
      e_rp = 4'b0000;
      if (exp_q.size() > 0 && t == int'(exp_q[0])) begin
        void'(exp_q.pop_front());
        if (REP_EN) e_rp = 4'b0100;
      end
      check_outs($sformatf("long_t%0d", t), e_st, e_pr, e_rl, e_rp, |(e_pr | e_rp));
      if (t == 100) check("long.fsm_held", {6'b0, key_fsm_state[5:4]}, REP_EN ? 8'(HELD) : 8'(PRESSED));
      if (t == LAT + 105) check("long.fsm_idle", {6'b0, key_fsm_state[5:4]}, 8'(IDLE));
      if (t == 104) key_data = 4'b1111;
    end
    check("long.queue_drained", 8'(exp_q.size()), 8'd0);

    // Reset while key 0 is held long; a fresh press follows the debounce interval.
    key_data = 4'b1110;
    repeat (90) step();
    check("rst.fsm_before", {6'b0, key_fsm_state[1:0]}, REP_EN ? 8'(HELD) : 8'(PRESSED));
    check("rst.state_before", {4'b0, key_state}, 8'h01);
    rst_n = 1'b0;
    #1;
    check_outs("rst.async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("rst.fsm", key_fsm_state, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_press = 0;
    for (int t = 1; t <= 40; t++) begin
      step();
      if (key_press[0]) n_press++;
      check($sformatf("rst.press_t%0d", t), {4'b0, key_press}, (t == LAT) ? 8'h01 : 8'h00);
      check($sformatf("rst.state_t%0d", t), {4'b0, key_state}, (t >= LAT) ? 8'h01 : 8'h00);
    end
    check("rst.press_count", 8'(n_press), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
